// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform.
//
// Reports the period (cycles between the last two rising edges) and the
// high time within that period, both as 16-bit cycle counts. A stuck
// input (no rising edge for 65535 cycles) raises a timeout level that
// stays up until the next valid measurement.
//
// Parameters:
//   SYNC_STAGES  number of synchroniser flops on pwm_i (must be >= 2)
//
// Ports:
//   clk        in   main clock
//   reset      in   synchronous, active-high reset
//   pwm_i      in   asynchronous PWM input
//   period_o   out  cycles between the last two rising edges
//   on_o       out  cycles the input was high within that period
//   valid_o    out  one-cycle pulse, period_o/on_o updated this cycle
//   timeout_o  out  level, no rising edge for 65535 cycles
//
// Build option:
//   PWM_CAPTURE_DEGLITCH_EN  when defined, a 3-sample agreement filter sits
//   between the synchroniser and the edge detector. Pulses and gaps shorter
//   than 3 cycles are ignored and latency grows by 2 cycles.

module pwm_capture #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_i,
    output logic [15:0] period_o,
    output logic [15:0] on_o,
    output logic        valid_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        MEASURE
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d_q;

    // Level seen by the measurement logic and its value one cycle earlier.
    logic lvl;
    logic lvl_prev;
    logic rise;

    state_e      state_q, state_d;
    logic [15:0] p_cnt_q, p_cnt_d;
    logic [15:0] h_cnt_q, h_cnt_d;
    logic [15:0] period_q, period_d;
    logic [15:0] on_q, on_d;
    logic        valid_q, valid_d;
    logic        timeout_q, timeout_d;

    assign s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_DEGLITCH_EN
    logic s_dd_q;
    logic filt_q, filt_d;

    // s, s_d_q and s_dd_q are three consecutive samples; the filtered level
    // only follows s once all three agree. The edge detector looks at the
    // next filtered value against the registered one, so the filter costs
    // exactly two extra cycles on both edges.
    always_comb begin
        filt_d = filt_q;
        if ((s == s_d_q) && (s == s_dd_q)) begin
            filt_d = s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_dd_q <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            s_dd_q <= s_d_q;
            filt_q <= filt_d;
        end
    end

    assign lvl      = filt_d;
    assign lvl_prev = filt_q;
`else
    assign lvl      = s;
    assign lvl_prev = s_d_q;
`endif

    assign rise = lvl & ~lvl_prev;

    always_comb begin
        state_d   = state_q;
        p_cnt_d   = p_cnt_q;
        h_cnt_d   = h_cnt_q;
        period_d  = period_q;
        on_d      = on_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        case (state_q)
            // Wait for a low level first so a period already in progress
            // when we start is never reported.
            WAIT_LOW: begin
                if (!lvl) begin
                    state_d = WAIT_RISE;
                end
            end

            WAIT_RISE: begin
                if (rise) begin
                    p_cnt_d = 16'd1;
                    h_cnt_d = 16'd1;
                    state_d = MEASURE;
                end
            end

            MEASURE: begin
                // The edge cycle itself counts as the first cycle of the new
                // period (and is high), hence the restart at 1.
                if (rise) begin
                    period_d  = p_cnt_q;
                    on_d      = h_cnt_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    p_cnt_d   = 16'd1;
                    h_cnt_d   = 16'd1;
                end else if (p_cnt_q == 16'hFFFF) begin
                    // Leaving MEASURE here is what keeps the counters from
                    // ever wrapping.
                    timeout_d = 1'b1;
                    state_d   = WAIT_RISE;
                end else begin
                    p_cnt_d = p_cnt_q + 16'd1;
                    if (lvl) begin
                        h_cnt_d = h_cnt_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = WAIT_LOW;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            s_d_q     <= 1'b0;
            state_q   <= WAIT_LOW;
            p_cnt_q   <= 16'd0;
            h_cnt_q   <= 16'd0;
            period_q  <= 16'd0;
            on_q      <= 16'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pwm_i};
            s_d_q     <= s;
            state_q   <= state_d;
            p_cnt_q   <= p_cnt_d;
            h_cnt_q   <= h_cnt_d;
            period_q  <= period_d;
            on_q      <= on_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_o  = period_q;
    assign on_o      = on_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture. A small PWM generator model (period and
// on time, on time latched at the start of each period) drives the main
// instance; a second instance receives a single 65535-cycle period while
// the main instance sits in its stuck-low phase.

module tb_pwm_capture;

`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pwm = 1'b0;
    logic pwm_l = 1'b0;

    logic [15:0] per, on, per_l, on_l;
    logic        vld, tmo, vld_l, tmo_l;

    always #5 clk = ~clk;

    pwm_capture #(.SYNC_STAGES(2)) u_dut (
        .clk(clk), .reset(reset), .pwm_i(pwm),
        .period_o(per), .on_o(on), .valid_o(vld), .timeout_o(tmo)
    );

    pwm_capture #(.SYNC_STAGES(2)) u_long (
        .clk(clk), .reset(reset), .pwm_i(pwm_l),
        .period_o(per_l), .on_o(on_l), .valid_o(vld_l), .timeout_o(tmo_l)
    );

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int nvalid = 0;
    int vld_cyc = -1;
    int rise_cyc = -1;
    int tmo_cyc = -1;
    int hold_err = 0;
    int order_err = 0;
    int short_per = 0;
    int last_per = 0;
    int last_on = 0;
    logic [15:0] prev_per = '0;
    logic [15:0] prev_on = '0;
    logic prev_pwm = 1'b0;

    int lt_nvalid = 0;
    int lt_tmo_seen = 0;
    int lt_per = 0;
    int lt_on = 0;

    int gP = 100;
    int gN = 0;
    int gN_next = 0;
    int gcnt = 0;
    bit glitch = 1'b0;

    int snap;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // One clock: drive inputs, wait for the edge, sample outputs 1 time unit later.
    task automatic step(input logic p);
        pwm   = p;
        pwm_l = ((cyc >= 700) && (cyc < 710)) || ((cyc >= 66235) && (cyc < 66245));
        if (p && !prev_pwm) rise_cyc = cyc;
        prev_pwm = p;
        @(posedge clk);
        #1;
        if (vld) begin
            nvalid++;
            vld_cyc  = cyc;
            last_per = int'(per);
            last_on  = int'(on);
            if (on > per) order_err++;
            if (on == 16'd1) short_per = int'(per);
        end else if (!reset && ((per != prev_per) || (on != prev_on))) begin
            hold_err++;
        end
        prev_per = per;
        prev_on  = on;
        if (tmo && (tmo_cyc < 0)) tmo_cyc = cyc;
        if (vld_l) begin
            lt_nvalid++;
            lt_per = int'(per_l);
            lt_on  = int'(on_l);
        end
        if (tmo_l) lt_tmo_seen++;
        cyc++;
    endtask

    task automatic gen(input int n);
        for (int i = 0; i < n; i++) begin
            logic p;
            if (gcnt == 0) gN = gN_next;
            p = (gcnt < gN) || (glitch && (gcnt == 60));
            gcnt = (gcnt + 1 == gP) ? 0 : gcnt + 1;
            step(p);
        end
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0);
        chk("rst_period", int'(per), 0);
        chk("rst_on", int'(on), 0);
        chk("rst_valid", int'(vld), 0);
        chk("rst_timeout", int'(tmo), 0);
        reset = 1'b0;

        // Steady 100/30 wave: rises at 0,100,200,300; first rise only arms.
        cyc = 0; gP = 100; gN = 30; gN_next = 30; gcnt = 0;
        gen(350);
        chk("steady_count", nvalid, 3);
        chk("steady_period", last_per, 100);
        chk("steady_on", last_on, 30);
        chk("steady_timeout", int'(tmo), 0);
        chk("latency", vld_cyc - rise_cyc, LAT);

        // Duty change 30 -> 70, takes effect at the period boundary (cycle 400).
        gN_next = 70;
        gen(300);
        chk("duty_count", nvalid, 6);
        chk("duty_period", last_per, 100);
        chk("duty_on", last_on, 70);

        // Stuck low from cycle 700; last valid came from the rise at 600.
        gN_next = 0;
        gen(66200 - 650);
        chk("stuck_timeout", int'(tmo), 1);
        chk("stuck_tmo_delay", tmo_cyc - vld_cyc, 65535);
        chk("stuck_no_valid", nvalid, 6);

        // Restore 30: rises at 66200 (arms) and 66300 (result).
        gN_next = 30;
        snap = nvalid;
        gen(100 + LAT);
        chk("restore_tmo_held", int'(tmo), 1);
        chk("restore_pre_count", nvalid, snap);
        gen(1);
        chk("restore_tmo_clear", int'(tmo), 0);
        chk("restore_count", nvalid, snap + 1);
        chk("restore_period", last_per, 100);
        chk("restore_on", last_on, 30);
        gen(49 - LAT);

        // Second instance: rises at 700 and 66235, 10 cycles high.
        chk("long_count", lt_nvalid, 1);
        chk("long_period", lt_per, 65535);
        chk("long_on", lt_on, 10);
        chk("long_no_timeout", lt_tmo_seen, 0);

        // Boundary: period 2, on 1.
        gP = 2; gN = 1; gN_next = 1; gcnt = 0;
        gen(20);
        snap = nvalid;
        gen(40);
`ifdef PWM_CAPTURE_DEGLITCH_EN
        chk("p2_count", nvalid - snap, 0);
`else
        chk("p2_count", nvalid - snap, 20);
        chk("p2_period", last_per, 2);
        chk("p2_on", last_on, 1);
`endif

        // Reset at cycle 50 of a 100-cycle period.
        gP = 100; gN = 30; gN_next = 30; gcnt = 0;
        gen(250);
        reset = 1'b1;
        gen(1);
        chk("midrst_period", int'(per), 0);
        chk("midrst_on", int'(on), 0);
        chk("midrst_valid", int'(vld), 0);
        chk("midrst_timeout", int'(tmo), 0);
        reset = 1'b0;
        snap = nvalid;
        gen(149 + LAT);
        chk("midrst_pre_count", nvalid, snap);
        gen(10);
        chk("midrst_count", nvalid, snap + 1);
        chk("midrst_period2", last_per, 100);
        chk("midrst_on2", last_on, 30);
        gen(90 - LAT);

        // 1-cycle glitch at position 60 of every period.
        glitch = 1'b1;
        short_per = 0;
        snap = nvalid;
        gen(300);
`ifdef PWM_CAPTURE_DEGLITCH_EN
        chk("glitch_count", nvalid - snap, 3);
        chk("glitch_period", last_per, 100);
        chk("glitch_on", last_on, 30);
        chk("glitch_short", short_per, 0);
`else
        chk("glitch_count", nvalid - snap, 6);
        chk("glitch_period", last_per, 60);
        chk("glitch_on", last_on, 30);
        chk("glitch_short", short_per, 40);
`endif

        chk("hold_between_valid", hold_err, 0);
        chk("on_le_period", order_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
